// File: rtl/dft_pkg.sv
// Shared types, constants and elaboration-time helpers for the streaming DFT.
package dft_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  // Cycles between the last MAC issue and the registered bin result.
  localparam int PIPE_LAT = 3;

  function automatic int out_width(input int data_w, input int logn);
    return data_w + logn + 1;
  endfunction

  function automatic int acc_width(input int data_w, input int coef_w, input int logn);
    return data_w + coef_w + logn;
  endfunction

  // Round half away from zero so the cos/sin tables stay exactly symmetric.
  function automatic int twiddle(input int p, input int n, input int coef_w, input bit is_sin);
    real ang;
    real v;
    ang = 6.283185307179586 * real'(p) / real'(n);
    v   = (is_sin ? $sin(ang) : $cos(ang)) * (real'(2 ** (coef_w - 1)) - 1.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

endpackage

// File: rtl/dft_stream_n_if.sv
// Sample-in / bin-out stream bundle for dft_stream_n.
interface dft_stream_n_if #(
  parameter int N      = 64,
  parameter int DATA_W = 16
);
  localparam int LOGN  = $clog2(N);
  localparam int OUT_W = dft_pkg::out_width(DATA_W, LOGN);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_sample;
  logic                     inverse;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_real;
  logic signed [OUT_W-1:0]  out_imag;
  logic [LOGN-1:0]          out_bin;
  logic                     out_last;
  logic                     busy;

  modport slave (
    input  in_valid, in_sample, inverse, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_bin, out_last, busy
  );

  modport master (
    output in_valid, in_sample, inverse, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_bin, out_last, busy
  );

endinterface

// File: rtl/dft_twiddle_rom.sv
// N-entry cos/sin twiddle table with a registered read port.
module dft_twiddle_rom
  import dft_pkg::*;
#(
  parameter int N      = 64,
  parameter int COEF_W = 16
) (
  input  logic                      clk,
  input  logic [$clog2(N)-1:0]      addr,
  output logic signed [COEF_W-1:0]  cos_q,
  output logic signed [COEF_W-1:0]  sin_q
);
  logic signed [COEF_W-1:0] cos_tab [N];
  logic signed [COEF_W-1:0] sin_tab [N];

  for (genvar i = 0; i < N; i++) begin : g_tab
    assign cos_tab[i] = COEF_W'(twiddle(i, N, COEF_W, 1'b0));
    assign sin_tab[i] = COEF_W'(twiddle(i, N, COEF_W, 1'b1));
  end

  always_ff @(posedge clk) begin
    cos_q <= cos_tab[addr];
    sin_q <= sin_tab[addr];
  end

endmodule

// File: rtl/dft_stream_n.sv
// Streaming N-point DFT: buffers one frame of real samples, then computes each
// bin with a single time-multiplexed complex MAC and streams the bins out in order.
//
//   state   | meaning
//   LOAD    | accepting samples x[0..N-1] into the buffer
//   COMPUTE | N MAC issues for bin k plus pipeline drain
//   OUTPUT  | bin k presented, waiting for out_ready
//
// Reset release is expected to be synchronised upstream.
module dft_stream_n
  import dft_pkg::*;
#(
  parameter int N             = 64,
  parameter int DATA_W        = 16,
  parameter int COEF_W        = 16,
  parameter int HALF_SPECTRUM = 0
) (
  input logic           clk,
  input logic           sreset,
  dft_stream_n_if.slave bus
);
  localparam int LOGN   = $clog2(N);
  localparam int OUT_W  = out_width(DATA_W, LOGN);
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, LOGN);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = LOGN + 1;

  localparam logic [LOGN-1:0]         K_LAST   = (HALF_SPECTRUM != 0) ? LOGN'(N / 2) : LOGN'(N - 1);
  localparam logic [CNT_W-1:0]        ISSUE_N  = CNT_W'(N);
  localparam logic [CNT_W-1:0]        DONE_CNT = CNT_W'(N + PIPE_LAT - 1);
  localparam logic signed [ACC_W-1:0] RND      = ACC_W'(1) << (COEF_W - 2);

  state_t                   state, state_nx;
  logic [LOGN-1:0]          n_idx, k, phase;
  logic [CNT_W-1:0]         cnt;
  logic                     inv_q;
  logic signed [DATA_W-1:0] sample_buf [N];
  logic signed [DATA_W-1:0] x_q;
  logic signed [COEF_W-1:0] cos_q, sin_q, sin_eff;
  logic signed [PROD_W-1:0] prod_re, prod_im;
  logic signed [ACC_W-1:0]  acc_re, acc_im;
  logic                     v1, v2;
  logic                     in_fire, issue, last_bin;

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = (state == OUTPUT);
  assign bus.busy      = (state != LOAD);

  assign in_fire  = bus.in_valid && (state == LOAD);
  assign issue    = (state == COMPUTE) && (cnt < ISSUE_N);
  assign last_bin = (k == K_LAST);
  assign sin_eff  = inv_q ? sin_q : -sin_q;

  dft_twiddle_rom #(
    .N      (N),
    .COEF_W (COEF_W)
  ) u_rom (
    .clk   (clk),
    .addr  (phase),
    .cos_q (cos_q),
    .sin_q (sin_q)
  );

  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (in_fire && n_idx == LOGN'(N - 1)) state_nx = COMPUTE;
      COMPUTE: if (cnt == DONE_CNT) state_nx = OUTPUT;
      OUTPUT:  if (bus.out_ready) state_nx = last_bin ? LOAD : COMPUTE;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_fire) sample_buf[n_idx] <= bus.in_sample;
  end

  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      n_idx        <= '0;
      k            <= '0;
      cnt          <= '0;
      phase        <= '0;
      inv_q        <= 1'b0;
      bus.out_real <= '0;
      bus.out_imag <= '0;
      bus.out_bin  <= '0;
      bus.out_last <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            n_idx <= n_idx + 1'b1;
            if (n_idx == '0) inv_q <= bus.inverse;
          end
        end
        COMPUTE: begin
          if (cnt == DONE_CNT) begin
            cnt          <= '0;
            phase        <= '0;
            bus.out_real <= OUT_W'((acc_re + RND) >>> (COEF_W - 1));
            bus.out_imag <= OUT_W'((acc_im + RND) >>> (COEF_W - 1));
            bus.out_bin  <= k;
            bus.out_last <= last_bin;
          end else begin
            cnt   <= cnt + 1'b1;
            phase <= phase + k;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) k <= last_bin ? '0 : k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // MAC pipeline: buffer/ROM read -> products -> accumulate.
  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      x_q     <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      prod_re <= '0;
      prod_im <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
    end else begin
      x_q     <= sample_buf[cnt[LOGN-1:0]];
      v1      <= issue;
      v2      <= v1;
      prod_re <= PROD_W'(x_q) * PROD_W'(cos_q);
      prod_im <= PROD_W'(x_q) * PROD_W'(sin_eff);
      if (state != COMPUTE) begin
        acc_re <= '0;
        acc_im <= '0;
      end else if (v2) begin
        acc_re <= acc_re + ACC_W'(prod_re);
        acc_im <= acc_im + ACC_W'(prod_im);
      end
    end
  end

endmodule
